pipelined_arith: RTL and testbench
==================================

# pipelined_arith

Parametrised, pipelined successor to the 16-bit combinational x/y → z datapath. It adds configurable width and pipeline depth, a per-transaction operation select, signed overflow detection and valid/ready flow control with backpressure. It sits between an upstream producer and a downstream consumer in the basic datapath examples. It is driven by the same harness style as the other examples: `clock` and `reset` ports, `io_` prefixed data ports.

## Interface
- `WIDTH`, default 16: operand and result width in bits; legal range 2..64.
- `STAGES`, default 2: number of register stages between input and output; legal range 1..4.

- `clock`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `io_in_valid`: input, 1 bit. Upstream offers an operand pair.
- `io_in_ready`: output, 1 bit. Block accepts the operand pair this cycle.
- `io_x`: input, WIDTH bits. Operand x, two's-complement signed.
- `io_y`: input, WIDTH bits. Operand y, two's-complement signed.
- `io_op`: input, 2 bits. Operation: 0 = x+y, 1 = x−y, 2 = signed min, 3 = signed max.
- `io_out_valid`: output, 1 bit. Result available.
- `io_out_ready`: input, 1 bit. Downstream accepts the result.
- `io_z`: output, WIDTH bits. Result.
- `io_overflow`: output, 1 bit. Signed overflow flag for the result on `io_z`.

## Operation
- A transfer occurs on a cycle with valid and ready both high, on either side.
- **Input capture:** on an input transfer, compute `io_op(io_x, io_y)` combinationally and load the result into stage 0 with its valid bit set.
- **Stage contents:** each stage holds {valid, z, overflow}. The last stage drives `io_out_valid`, `io_z` and `io_overflow`.
- **Stage advance:** stage i advances when stage i+1 is empty or stage i+1 advances. The last stage advances on an output transfer.
- **Ready rule:** `io_in_ready` = stage 0 empty OR stage 0 advances. This is combinational from `io_out_ready` through the stage valid bits; there is no combinational path from `io_in_valid`.
- **Bubbles:** compress. A full stage moves into an empty downstream stage even while the output stalls.
- **Arithmetic:**
  - Add and sub are computed at WIDTH+1 bits.
  - Overflow is set when operand signs make a signed overflow possible and the result sign differs: for add, x and y have the same sign; for sub, x and y have differing signs.
  - Min and max compare as signed and always report overflow = 0.
- **No reordering or dropping:** results leave in acceptance order. Each accepted pair produces exactly one result.
- **Stall stability:** while `io_out_valid`=1 and `io_out_ready`=0, `io_z` and `io_overflow` are held stable.

## Timing
- **Reset values:** all stage valid bits = 0, so `io_out_valid`=0. `io_z`=0 and `io_overflow`=0. `io_in_ready`=1 in the first cycle after reset.
- **Latency:** a pair accepted at edge N appears at the output after edge N+STAGES−1, i.e. visible in the cycle following that edge, when there is no backpressure. With STAGES=1 the result is visible the cycle after acceptance.
- **Throughput:** one transaction per cycle with `io_out_ready` held high.
- **Capacity:** exactly STAGES results under full backpressure. Once full, `io_in_ready`=0 until an output transfer.
- **Simultaneous in/out transfer when full:** allowed. Occupancy is unchanged.
- **Reset mid-operation:** all in-flight results are discarded. Outputs take their reset values at the next edge and no stale result is presented afterward.
- **Illegal parameters:** out-of-range WIDTH or STAGES halts simulation with an error at elaboration.

## Configuration
- Macro: `PIPELINED_ARITH_SATURATE_EN`.
- **Defined:** add and sub saturate on overflow to the signed maximum, 2^(WIDTH−1)−1, or minimum, −2^(WIDTH−1). `io_overflow` still reports that saturation occurred.
- **Undefined:** add and sub wrap modulo 2^WIDTH, and `io_overflow` reports the wrap.
- Min and max behave identically in both builds.

## Test plan
- **Latency:** WIDTH=16, STAGES=2, `io_out_ready`=1; apply x=3, y=4, op=0 → `io_z`=7 visible 2 cycles after acceptance, `io_overflow`=0.
- **Overflow:** x=0x7FFF, y=0x0001, op=0 → wrap build gives `io_z`=0x8000 with `io_overflow`=1; `PIPELINED_ARITH_SATURATE_EN` build gives `io_z`=0x7FFF with `io_overflow`=1.
- **Signed compare:** x=0xFFFE (−2), y=0x0003; op=2 → `io_z`=0xFFFE; op=3 → `io_z`=0x0003; `io_overflow`=0 for both.
- **Backpressure:** hold `io_out_ready`=0 with continuous input valid → exactly STAGES pairs accepted, then `io_in_ready`=0. Release → results drain in order, with no loss and no duplicates.
- **Streaming scoreboard:** 1000 random transactions with random valid and ready toggling → every result matches the reference model in order, and `io_z` is stable during stalls.
- **Reset mid-operation:** assert `reset` for one cycle with 2 results in flight → `io_out_valid`=0 the next cycle, `io_in_ready`=1, and no old result appears afterward.

Source files
------------

// File: rtl/pipelined_arith.sv
// Pipelined signed add/sub/min/max with valid/ready flow control and overflow flag.
// Define PIPELINED_ARITH_SATURATE_EN to saturate add/sub on overflow instead of wrapping.
module pipelined_arith #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_x,
    input  logic [WIDTH-1:0] io_y,
    input  logic [1:0]       io_op,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_z,
    output logic             io_overflow
);

    localparam int unsigned EXT_W = WIDTH + 1;

    if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > 4) begin : g_bad_param
        $error("pipelined_arith: illegal WIDTH=%0d or STAGES=%0d", WIDTH, STAGES);
    end

    logic                vld_q [STAGES];
    logic [WIDTH-1:0]    z_q   [STAGES];
    logic                ov_q  [STAGES];
    logic [STAGES-1:0]   vld_c;
    logic [STAGES-1:0]   adv_c;
    logic                in_fire_c;
    logic [EXT_W-1:0]    x_ext_c;
    logic [EXT_W-1:0]    y_ext_c;
    logic [EXT_W-1:0]    arith_c;
    logic [WIDTH-1:0]    res_c;
    logic                res_ov_c;

    // Result datapath: add/sub at WIDTH+1 bits; overflow when the two top bits disagree.
    always_comb begin
        x_ext_c  = {io_x[WIDTH-1], io_x};
        y_ext_c  = {io_y[WIDTH-1], io_y};
        arith_c  = '0;
        res_c    = '0;
        res_ov_c = 1'b0;
        case (io_op)
            2'd0, 2'd1: begin
                arith_c  = (io_op == 2'd0) ? (x_ext_c + y_ext_c) : (x_ext_c - y_ext_c);
                res_c    = arith_c[WIDTH-1:0];
                res_ov_c = arith_c[WIDTH] ^ arith_c[WIDTH-1];
`ifdef PIPELINED_ARITH_SATURATE_EN
                // The extra top bit carries the true sign, selecting the clamp direction.
                if (res_ov_c) begin
                    res_c = arith_c[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
            2'd2:    res_c = ($signed(io_x) < $signed(io_y)) ? io_x : io_y;
            default: res_c = ($signed(io_x) > $signed(io_y)) ? io_x : io_y;
        endcase
    end

    assign io_in_ready  = ~vld_c[0] | adv_c[0];
    assign in_fire_c    = io_in_valid & io_in_ready;
    assign io_out_valid = vld_q[STAGES-1];
    assign io_z         = z_q[STAGES-1];
    assign io_overflow  = ov_q[STAGES-1];

    for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
        assign vld_c[i] = vld_q[i];

        // A stage advances if any downstream stage is empty or the output transfers.
        if (i == int'(STAGES) - 1) begin : g_last
            assign adv_c[i] = vld_q[i] & io_out_ready;
        end else begin : g_mid
            assign adv_c[i] = vld_q[i] & (~(&vld_c[STAGES-1:i+1]) | io_out_ready);
        end

        if (i == 0) begin : g_first
            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_q[i] <= 1'b0;
                    z_q[i]   <= '0;
                    ov_q[i]  <= 1'b0;
                end else if (in_fire_c) begin
                    vld_q[i] <= 1'b1;
                    z_q[i]   <= res_c;
                    ov_q[i]  <= res_ov_c;
                end else if (adv_c[i]) begin
                    vld_q[i] <= 1'b0;
                end
            end
        end else begin : g_next
            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_q[i] <= 1'b0;
                    z_q[i]   <= '0;
                    ov_q[i]  <= 1'b0;
                end else if (adv_c[i-1]) begin
                    vld_q[i] <= 1'b1;
                    z_q[i]   <= z_q[i-1];
                    ov_q[i]  <= ov_q[i-1];
                end else if (adv_c[i]) begin
                    vld_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_arith.sv
// Directed and randomised self-checking bench for pipelined_arith (WIDTH=16, STAGES=2).
module tb_pipelined_arith;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 2;
`ifdef PIPELINED_ARITH_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_x;
    logic [WIDTH-1:0] io_y;
    logic [1:0]       io_op;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_z;
    logic             io_overflow;

    int checks = 0;
    int errors = 0;

    pipelined_arith #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_x        (io_x),
        .io_y        (io_y),
        .io_op       (io_op),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_z        (io_z),
        .io_overflow (io_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Integer reference model: {overflow, z}
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic [1:0] op);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int r;
        logic ov = 1'b0;
        case (op)
            2'd0:    r = sx + sy;
            2'd1:    r = sx - sy;
            2'd2:    r = (sx < sy) ? sx : sy;
            default: r = (sx > sy) ? sx : sy;
        endcase
        if (op < 2'd2 && (r > 32767 || r < -32768)) begin
            ov = 1'b1;
            if (SAT) r = (r > 0) ? 32767 : -32768;
        end
        return {ov, 16'(r)};
    endfunction

    // Send one pair with no backpressure and check it after STAGES-1 further edges.
    task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [1:0] op, input logic [15:0] ez, input logic eov);
        io_in_valid  = 1'b1;
        io_x         = x;
        io_y         = y;
        io_op        = op;
        io_out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(io_in_ready), 32'(1));
        tick();
        io_in_valid = 1'b0;
        if (STAGES > 1) chk({tag, "_early"}, 32'(io_out_valid), 32'(0));
        repeat (STAGES - 1) tick();
        chk({tag, "_valid"}, 32'(io_out_valid), 32'(1));
        chk({tag, "_z"}, 32'(io_z), 32'(ez));
        chk({tag, "_ov"}, 32'(io_overflow), 32'(eov));
        tick();
    endtask

    logic [16:0] exp_q[$];
    logic [16:0] e;
    int          n_acc;
    int          n_out;
    int          sent;
    int          recv;
    logic        prev_stall;
    logic [15:0] prev_z;
    logic        prev_ov;
    logic [15:0] held_z;

    initial begin
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_x         = '0;
        io_y         = '0;
        io_op        = '0;
        io_out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(io_out_valid), 32'(0));
        chk("rst_z", 32'(io_z), 32'(0));
        chk("rst_ov", 32'(io_overflow), 32'(0));
        chk("rst_in_ready", 32'(io_in_ready), 32'(1));

        run_one("lat_add",    16'h0003, 16'h0004, 2'd0, 16'h0007, 1'b0);
        run_one("ovf_add_p",  16'h7FFF, 16'h0001, 2'd0, SAT ? 16'h7FFF : 16'h8000, 1'b1);
        run_one("ovf_add_n",  16'h8000, 16'hFFFF, 2'd0, SAT ? 16'h8000 : 16'h7FFF, 1'b1);
        run_one("ovf_sub_n",  16'h8000, 16'h0001, 2'd1, SAT ? 16'h8000 : 16'h7FFF, 1'b1);
        run_one("ovf_sub_p",  16'h7FFF, 16'hFFFF, 2'd1, SAT ? 16'h7FFF : 16'h8000, 1'b1);
        run_one("sub_neg",    16'h0005, 16'h0007, 2'd1, 16'hFFFE, 1'b0);
        run_one("add_negneg", 16'hFFFF, 16'hFFFF, 2'd0, 16'hFFFE, 1'b0);
        run_one("min_sgn",    16'hFFFE, 16'h0003, 2'd2, 16'hFFFE, 1'b0);
        run_one("max_sgn",    16'hFFFE, 16'h0003, 2'd3, 16'h0003, 1'b0);
        run_one("min_ext",    16'h8000, 16'h7FFF, 2'd2, 16'h8000, 1'b0);
        run_one("max_ext",    16'h8000, 16'h7FFF, 2'd3, 16'h7FFF, 1'b0);

        // Backpressure: fill, verify capacity and stall stability, then drain in order.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_y         = 16'h0001;
        io_op        = 2'd0;
        n_acc        = 0;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            io_x = 16'(100 + n_acc);
            #1;
            if (io_in_ready) begin
                exp_q.push_back({1'b0, 16'(101 + n_acc)});
                n_acc++;
            end
            tick();
        end
        chk("bp_accepted", 32'(n_acc), 32'(STAGES));
        chk("bp_in_ready", 32'(io_in_ready), 32'(0));
        chk("bp_out_valid", 32'(io_out_valid), 32'(1));
        held_z = io_z;
        tick();
        chk("bp_hold_z", 32'(io_z), 32'(held_z));
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        n_out        = 0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (io_out_valid) begin
                chk("bp_no_dup", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bp_drain_z", 32'(io_z), 32'(e[15:0]));
                end
                n_out++;
            end
            tick();
        end
        chk("bp_drained", 32'(n_out), 32'(2));

        // Random streaming against the reference model, with stall stability.
        exp_q.delete();
        sent       = 0;
        recv       = 0;
        prev_stall = 1'b0;
        prev_z     = '0;
        prev_ov    = 1'b0;
        for (int c = 0; c < 20000 && recv < 1000; c++) begin
            io_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            io_x         = 16'($urandom);
            io_y         = 16'($urandom);
            io_op        = 2'($urandom);
            io_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                chk("stall_valid", 32'(io_out_valid), 32'(1));
                chk("stall_z", 32'(io_z), 32'(prev_z));
                chk("stall_ov", 32'(io_overflow), 32'(prev_ov));
            end
            if (io_in_valid && io_in_ready) begin
                exp_q.push_back(model(io_x, io_y, io_op));
                sent++;
            end
            if (io_out_valid && io_out_ready) begin
                chk("stream_no_extra", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stream_z", 32'(io_z), 32'(e[15:0]));
                    chk("stream_ov", 32'(io_overflow), 32'(e[16]));
                end
                recv++;
            end
            prev_stall = io_out_valid && !io_out_ready;
            prev_z     = io_z;
            prev_ov    = io_overflow;
            tick();
        end
        chk("stream_sent", 32'(sent), 32'(1000));
        chk("stream_recv", 32'(recv), 32'(1000));

        // Reset with two results in flight discards them.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_x         = 16'h0005;
        io_y         = 16'h0006;
        io_op        = 2'd0;
        repeat (2) tick();
        io_in_valid = 1'b0;
        #1;
        chk("mid_full", 32'(io_out_valid), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(io_out_valid), 32'(0));
        chk("mid_rst_ready", 32'(io_in_ready), 32'(1));
        chk("mid_rst_z", 32'(io_z), 32'(0));
        io_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_no_stale", 32'(io_out_valid), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
